// File: rtl/shift_pkg.sv
// Shared widths, default shifter latency and result record for the shift sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_pkg;
    localparam int DATA_W    = 32;
    localparam int AMT_W     = 5;
    localparam int SHIFT_LAT = 4;
    localparam int RES_TAG_W = 4;

    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [RES_TAG_W-1:0] tag;
    } shift_res_t;
endpackage

// File: rtl/shift_fifo.sv
// Synchronous result FIFO; full/empty come from a count register, pointers wrap naturally.
// Latency: a push becomes visible at the head one clock later.
// Backpressure: none internally; the caller must never push while full.
module shift_fifo
    import shift_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = shift_res_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  T                       push_dat,
    input  logic                   pop,
    output T                       pop_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          full;

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    // Head reads as zero while empty so nothing stale is ever presented.
    assign pop_dat = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(push && full));
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/shift_seq.sv
// Request sequencer around a non-stallable shifter; optional counters under SHIFT_SEQ_STATS_EN.
// Latency: accept at t gives rsp_valid at t+LAT+1 into an empty, unblocked result FIFO.
// Backpressure: req_ready is a credit check (buffered + in flight < DEPTH) on registered state.
module shift_seq
    import shift_pkg::*;
#(
    parameter int LAT   = SHIFT_LAT,
    parameter int DEPTH = 8,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    input  logic [AMT_W-1:0]  req_amt,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [DATA_W-1:0] sh_a,
    output logic [AMT_W-1:0]  sh_s,
    input  logic [DATA_W-1:0] sh_o,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag
`ifdef SHIFT_SEQ_STATS_EN
    ,
    output logic [31:0]       stat_acc,
    output logic [31:0]       stat_stall
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(LAT + 1);
    localparam int SW = CW + IW;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } res_t;

    logic             accept;
    logic [LAT-1:0]   dl_vld;
    logic [TAG_W-1:0] dl_tag [LAT];
    logic [IW-1:0]    inflight;
    logic [CW-1:0]    fifo_count;
    res_t             push_res;
    res_t             head;

    // Every accepted request reserves a FIFO slot up front, so captures never overflow.
    assign req_ready = (SW'(fifo_count) + SW'(inflight)) < SW'(DEPTH);
    assign accept    = req_valid && req_ready;

    assign sh_a = accept ? req_data : '0;
    assign sh_s = accept ? req_amt  : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            dl_vld   <= '0;
            inflight <= '0;
        end else begin
            dl_vld[0] <= accept;
            for (int i = 1; i < LAT; i++) begin
                dl_vld[i] <= dl_vld[i-1];
            end
            inflight <= inflight + IW'(accept) - IW'(dl_vld[LAT-1]);
        end
    end

    // Tags only matter alongside a set vld bit, so they need no reset.
    always_ff @(posedge clk) begin
        dl_tag[0] <= req_tag;
        for (int i = 1; i < LAT; i++) begin
            dl_tag[i] <= dl_tag[i-1];
        end
    end

    assign push_res.data = sh_o;
    assign push_res.tag  = dl_tag[LAT-1];

    shift_fifo #(
        .DEPTH (DEPTH),
        .T     (res_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (dl_vld[LAT-1]),
        .push_dat (push_res),
        .pop      (rsp_ready),
        .pop_dat  (head),
        .count    (fifo_count)
    );

    assign rsp_valid = (fifo_count != '0);
    assign rsp_data  = head.data;
    assign rsp_tag   = head.tag;

`ifdef SHIFT_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_acc   <= '0;
            stat_stall <= '0;
        end else begin
            if (accept) begin
                stat_acc <= stat_acc + 32'd1;
            end
            if (req_valid && !req_ready) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif
endmodule
